// File: rtl/smac_ctrl_pkg.sv
// Shared control definitions for the SMAC filter-group scheduler:
// FSM state encoding and grouping constants.
package smac_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      LOAD,
      ISSUE,
      DONE
   } state_t;

   localparam int GRP_MAX = 4;   // filters per counter group
   localparam int IDX_W   = 5;   // absolute filter index width (32 filters)

endpackage

// File: rtl/fil_group_sched.sv
// Filter-group scheduler: splits a job of num_fil filters into groups of up
// to four, programs the group counter and strobes one filter per ready cycle.
module fil_group_sched
   import smac_ctrl_pkg::*;
#(
   parameter int NFIL_W = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [NFIL_W-1:0] num_fil,
   input  logic              abort,
   input  logic              acc_ready,
   output logic              cnt_clear,
   output logic              cnt_load,
   output logic [2:0]        max_val,
   output logic              valid_ac3,
   output logic [IDX_W-1:0]  fil_idx,
   output logic              busy,
   output logic              done
);

   localparam int GRP_W = IDX_W - 2;

   state_t            state;
   logic [NFIL_W-1:0] rem;
   logic [2:0]        gsz;
   logic [2:0]        grp_size;
   logic [1:0]        k;
   logic [GRP_W-1:0]  grp;
   logic              aborting;   // the CLEAR now in progress ends the job
   logic              active;
   logic              go;
   logic              strobe;
   logic              last_strobe;

   // NOTE: every signal written here gets a value on every path, so no latch is inferred.
   always_comb begin
      grp_size    = (rem >= NFIL_W'(GRP_MAX)) ? 3'(GRP_MAX) : rem[2:0];
      active      = (state != IDLE);
      go          = (state == IDLE) && start && !abort;
      strobe      = (state == ISSUE) && acc_ready && !abort;
      last_strobe = strobe && (({1'b0, k} + 3'd1) == gsz);
   end

   // Abort must suppress the strobe and load in the very cycle it arrives.
   assign busy      = active;
   assign cnt_clear = (state == CLEAR);
   assign cnt_load  = (state == LOAD) && !abort;
   assign max_val   = cnt_load ? grp_size : 3'd0;
   assign valid_ac3 = strobe;
   assign fil_idx   = (state == ISSUE) ? {grp, k} : '0;
   assign done      = (state == DONE) && !abort;

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else if (abort && active) begin
         state <= CLEAR;
      end else begin
         case (state)
            IDLE:    if (go) state <= (num_fil != '0) ? CLEAR : DONE;
            CLEAR:   state <= aborting ? IDLE : LOAD;
            LOAD:    state <= ISSUE;
            ISSUE:   if (last_strobe) state <= (rem != '0) ? LOAD : DONE;
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem      <= '0;
         gsz      <= '0;
         k        <= '0;
         grp      <= '0;
         aborting <= 1'b0;
      end else begin
         aborting <= abort && active;
         if (go && (num_fil != '0)) begin
            rem <= num_fil;
            grp <= '0;
            k   <= '0;
         end else if ((state == LOAD) && !abort) begin
            gsz <= grp_size;
            rem <= rem - NFIL_W'(grp_size);
            k   <= '0;
         end else if (strobe) begin
            if (last_strobe) begin
               k <= '0;
               if (rem != '0) grp <= grp + GRP_W'(1);
            end else begin
               k <= k + 2'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_fil_group_sched.sv
// Self-checking bench for fil_group_sched: directed scenarios plus randomized
// jobs, compared against a queue-of-events reference model.
module tb_fil_group_sched;

   localparam int NFIL_W = 6;

   typedef enum {EV_CLEAR, EV_LOAD, EV_STROBE, EV_DONE} ev_kind_t;
   typedef struct {
      ev_kind_t kind;
      int       val;
   } ev_t;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic [NFIL_W-1:0] num_fil;
   logic              abort;
   logic              acc_ready;
   logic              cnt_clear;
   logic              cnt_load;
   logic [2:0]        max_val;
   logic              valid_ac3;
   logic [4:0]        fil_idx;
   logic              busy;
   logic              done;

   ev_t q[$];
   int  checks  = 0;
   int  passes  = 0;
   int  n_strb  = 0;
   int  n_done  = 0;
   int  n_load  = 0;
   int  n_clr   = 0;

   fil_group_sched #(.NFIL_W(NFIL_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .num_fil   (num_fil),
      .abort     (abort),
      .acc_ready (acc_ready),
      .cnt_clear (cnt_clear),
      .cnt_load  (cnt_load),
      .max_val   (max_val),
      .valid_ac3 (valid_ac3),
      .fil_idx   (fil_idx),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs === exp) passes++;
      else $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, obs, exp);
   endtask

   // Expected event list of a job: clear, then per group a load and its strobes, then done.
   task automatic build_job(input int n);
      int left = n;
      int idx  = 0;
      if (n != 0) q.push_back('{EV_CLEAR, 0});
      while (left > 0) begin
         int sz = (left < 4) ? left : 4;
         q.push_back('{EV_LOAD, sz});
         for (int j = 0; j < sz; j++) begin
            q.push_back('{EV_STROBE, idx});
            idx++;
         end
         left -= sz;
      end
      q.push_back('{EV_DONE, 0});
   endtask

   task automatic step(input logic st, input int n, input logic ab, input logic rdy);
      ev_t  head;
      logic e_clr = 1'b0, e_ld = 1'b0, e_v = 1'b0, e_dn = 1'b0, e_busy, chk_idx = 1'b0;
      int   e_mv = 0, e_idx = 0;
      @(negedge clk);
      start = st; num_fil = NFIL_W'(n); abort = ab; acc_ready = rdy;
      #1;
      e_busy = (q.size() != 0);
      if (e_busy) begin
         head = q[0];
         if (ab) begin
            e_clr = (head.kind == EV_CLEAR);
            q.delete();
            q.push_back('{EV_CLEAR, 0});
         end else begin
            case (head.kind)
               EV_CLEAR:  e_clr = 1'b1;
               EV_LOAD:   begin e_ld = 1'b1; e_mv = head.val; end
               EV_STROBE: begin e_v = rdy; chk_idx = 1'b1; e_idx = head.val; end
               EV_DONE:   e_dn = 1'b1;
            endcase
            if (!(head.kind == EV_STROBE && !rdy)) void'(q.pop_front());
         end
      end else if (st && !ab) begin
         build_job(n);
      end
      check("busy", busy, e_busy);
      check("cnt_clear", cnt_clear, e_clr);
      check("cnt_load", cnt_load, e_ld);
      check("valid_ac3", valid_ac3, e_v);
      check("done", done, e_dn);
      if (e_ld) check("max_val", max_val, e_mv);
      if (chk_idx) check("fil_idx", fil_idx, e_idx);
      if (valid_ac3 === 1'b1) n_strb++;
      if (done === 1'b1) n_done++;
      if (cnt_load === 1'b1) n_load++;
      if (cnt_clear === 1'b1) n_clr++;
   endtask

   task automatic drain(input int budget);
      for (int c = 0; c < budget && q.size() != 0; c++) step(1'b0, 0, 1'b0, 1'b1);
      check("drain_budget", q.size(), 0);
   endtask

   task automatic zero_outputs(input string tag);
      check(tag, {cnt_clear, cnt_load, max_val, valid_ac3, fil_idx, busy, done}, 0);
   endtask

   task automatic reset_pulse();
      @(negedge clk);
      start = 1'b0; abort = 1'b0; acc_ready = 1'b1;
      #2 rst_n = 1'b0;
      #1 zero_outputs("reset_outputs");
      q.delete();
      @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   initial begin
      int pat[6] = '{1, 0, 0, 1, 0, 1};
      int s0, d0, l0, c0;

      rst_n = 1'b0; start = 1'b0; num_fil = '0; abort = 1'b0; acc_ready = 1'b0;
      #1 zero_outputs("por_outputs");
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;

      // Four filters, always ready: clear, load 4, strobes 0..3, done.
      step(1'b1, 4, 1'b0, 1'b1);
      drain(20);

      // Ten filters: loads 4, 4, 2 with a single clear.
      s0 = n_strb; d0 = n_done; l0 = n_load; c0 = n_clr;
      step(1'b1, 10, 1'b0, 1'b1);
      drain(40);
      check("n10_strobes", n_strb - s0, 10);
      check("n10_loads", n_load - l0, 3);
      check("n10_clears", n_clr - c0, 1);
      check("n10_done", n_done - d0, 1);

      // Three filters under a stalling accumulator.
      s0 = n_strb;
      step(1'b1, 3, 1'b0, 1'b1);
      step(1'b0, 0, 1'b0, 1'b1);
      step(1'b0, 0, 1'b0, 1'b1);
      foreach (pat[i]) step(1'b0, 0, 1'b0, pat[i][0]);
      drain(10);
      check("stall_strobes", n_strb - s0, 3);

      // Empty job: done only.
      s0 = n_strb; l0 = n_load; c0 = n_clr; d0 = n_done;
      step(1'b1, 0, 1'b0, 1'b1);
      drain(5);
      check("n0_traffic", (n_strb - s0) + (n_load - l0) + (n_clr - c0), 0);
      check("n0_done", n_done - d0, 1);

      // Abort after the fifth strobe of a nine-filter job.
      s0 = n_strb; d0 = n_done; c0 = n_clr;
      step(1'b1, 9, 1'b0, 1'b1);
      for (int c = 0; c < 20 && (n_strb - s0) < 5; c++) step(1'b0, 0, 1'b0, 1'b1);
      step(1'b0, 0, 1'b1, 1'b1);
      repeat (4) step(1'b0, 0, 1'b0, 1'b1);
      check("abort_strobes", n_strb - s0, 5);
      check("abort_clears", n_clr - c0, 2);
      check("abort_no_done", n_done - d0, 0);

      // Abort together with start in IDLE: no job.
      step(1'b1, 5, 1'b1, 1'b1);
      step(1'b0, 0, 1'b0, 1'b1);

      // Reset during ISSUE, then a two-filter job right after release.
      step(1'b1, 8, 1'b0, 1'b1);
      repeat (4) step(1'b0, 0, 1'b0, 1'b1);
      reset_pulse();
      d0 = n_done; s0 = n_strb;
      step(1'b1, 2, 1'b0, 1'b1);
      drain(10);
      check("post_reset_strobes", n_strb - s0, 2);
      check("post_reset_done", n_done - d0, 1);

      // Randomized jobs with stalls, stray starts, aborts and occasional resets.
      for (int j = 0; j < 60; j++) begin
         step(1'b1, int'($urandom_range(0, 32)), $urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)));
         for (int c = 0; c < 400 && q.size() != 0; c++) begin
            if (c == 6 && (j % 12) == 5) reset_pulse();
            else step($urandom_range(0, 3) == 0, int'($urandom_range(0, 32)),
                      $urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0);
         end
         check("job_budget", q.size(), 0);
         if ($urandom_range(0, 1) == 1) step(1'b0, 0, $urandom_range(0, 1) == 1, 1'b1);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
